hazard_issue_unit: RTL and testbench

- Issue-side companion to the ID/EX control register: decides, cycle by cycle, which ex/mem/wb control bundle the ID stage sends into ID/EX.
- Passes decoded control through, or substitutes an all-zero bubble.
- Detects load-use hazards against the instruction in EX and stalls PC and IF/ID.
- On a taken branch resolved in EX, flushes IF/ID and injects bubbles for a programmable number of cycles.
- Keeps saturating stall/flush event counters for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/sat_counter.sv | 19 +
 rtl/hazard_issue_unit.sv | 132 +++++++++++++
 tb/tb_hazard_issue_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: default widths, control-bundle bit map
// and the issue-unit FSM states.
package pipe_ctrl_pkg;

  localparam int CTRL_W_DEF = 4;
  localparam int REG_AW_DEF = 4;

  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;
  localparam int REG_WRITE = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_issue_unit.sv
// Chooses the control bundle sent into ID/EX: decoded control or a bubble,
// with load-use stalls, taken-branch flushes and saturating event counters.
module hazard_issue_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W              = CTRL_W_DEF,
  parameter int REG_AW              = REG_AW_DEF,
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ex_ctrl,
  input  logic [CTRL_W-1:0] id_mem_ctrl,
  input  logic [CTRL_W-1:0] id_wb_ctrl,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_uses_rn,
  input  logic              id_uses_rm,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [CTRL_W-1:0] ex_mem_ctrl,
  input  logic [CTRL_W-1:0] ex_wb_ctrl,
  input  logic              branch_taken_ex,
  output logic [CTRL_W-1:0] ex_control_out,
  output logic [CTRL_W-1:0] mem_control_out,
  output logic [CTRL_W-1:0] wb_control_out,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic [1:0]        fsm_state
);

  localparam int MAX_CYC = (LOAD_STALL_CYCLES > BRANCH_FLUSH_CYCLES) ?
                           LOAD_STALL_CYCLES : BRANCH_FLUSH_CYCLES;
  localparam int CYC_W = $clog2(MAX_CYC + 1);

  // Reload values count the remaining bubbles after the one issued on entry.
  localparam logic [CYC_W-1:0] LU_RELOAD =
    (LOAD_STALL_CYCLES > 1) ? CYC_W'(LOAD_STALL_CYCLES - 2) : '0;
  localparam logic [CYC_W-1:0] BR_RELOAD =
    (BRANCH_FLUSH_CYCLES > 1) ? CYC_W'(BRANCH_FLUSH_CYCLES - 2) : '0;

  state_t           state, state_nxt;
  logic [CYC_W-1:0] cnt, cnt_nxt;
  logic             hz, bubble, stall, flush, stall_inc, flush_inc;
  logic             unused_bits;

  assign unused_bits = ^{ex_mem_ctrl, ex_wb_ctrl};

  assign hz = id_valid & ex_mem_ctrl[MEM_READ] & ex_wb_ctrl[REG_WRITE] &
              ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bubble    = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      RUN, LU_STALL: begin
        // A taken branch wins over both a new hazard and an ongoing stall.
        if (branch_taken_ex) begin
          flush     = 1'b1;
          flush_inc = 1'b1;
          state_nxt = (BRANCH_FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
          cnt_nxt   = BR_RELOAD;
        end else if (state == LU_STALL) begin
          stall = 1'b1;
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - 1'b1;
        end else if (hz) begin
          stall     = 1'b1;
          stall_inc = 1'b1;
          state_nxt = (LOAD_STALL_CYCLES > 1) ? LU_STALL : RUN;
          cnt_nxt   = LU_RELOAD;
        end else begin
          bubble = ~id_valid;
        end
      end
      BR_FLUSH: begin
        flush = 1'b1;
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    if (reset) begin
      bubble = 1'b1;
      stall  = 1'b0;
      flush  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign ex_control_out  = bubble ? '0 : id_ex_ctrl;
  assign mem_control_out = bubble ? '0 : id_mem_ctrl;
  assign wb_control_out  = bubble ? '0 : id_wb_ctrl;
  assign stall_pc        = stall;
  assign stall_if_id     = stall;
  assign flush_if_id     = flush;
  assign fsm_state       = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_issue_unit.sv
// Bench for hazard_issue_unit: three parameterisations share one stimulus
// stream and are checked against a bubble-budget reference model.
module tb_hazard_issue_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid, id_uses_rn, id_uses_rm, branch_taken_ex;
  logic [3:0] id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, id_rn, id_rm, ex_rd;
  logic [3:0] ex_mem_ctrl, ex_wb_ctrl;

  logic [3:0]  a_ex, a_mem, a_wb, b_ex, b_mem, b_wb, c_ex, c_mem, c_wb;
  logic        a_spc, a_sif, a_fl, b_spc, b_sif, b_fl, c_spc, c_sif, c_fl;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  logic [1:0]  c_sc, c_fc;
  logic [1:0]  a_st, b_st, c_st;

  int n_pass = 0;
  int n_total = 0;

  // Model: per instance, remaining bubbles of the current stall/flush and event counts.
  int lsc_p[3]  = '{1, 3, 1};
  int bfc_p[3]  = '{2, 3, 2};
  int cmax_p[3] = '{65535, 65535, 3};
  int rem_stall[3], rem_flush[3], m_sc[3], m_fc[3];
  logic [46:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_issue_unit u_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ex_ctrl(id_ex_ctrl),
    .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
    .ex_mem_ctrl(ex_mem_ctrl), .ex_wb_ctrl(ex_wb_ctrl), .branch_taken_ex(branch_taken_ex),
    .ex_control_out(a_ex), .mem_control_out(a_mem), .wb_control_out(a_wb),
    .stall_pc(a_spc), .stall_if_id(a_sif), .flush_if_id(a_fl),
    .stall_count(a_sc), .flush_count(a_fc), .fsm_state(a_st));

  hazard_issue_unit #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(3)) u_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ex_ctrl(id_ex_ctrl),
    .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
    .ex_mem_ctrl(ex_mem_ctrl), .ex_wb_ctrl(ex_wb_ctrl), .branch_taken_ex(branch_taken_ex),
    .ex_control_out(b_ex), .mem_control_out(b_mem), .wb_control_out(b_wb),
    .stall_pc(b_spc), .stall_if_id(b_sif), .flush_if_id(b_fl),
    .stall_count(b_sc), .flush_count(b_fc), .fsm_state(b_st));

  hazard_issue_unit #(.CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ex_ctrl(id_ex_ctrl),
    .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_rd(ex_rd),
    .ex_mem_ctrl(ex_mem_ctrl), .ex_wb_ctrl(ex_wb_ctrl), .branch_taken_ex(branch_taken_ex),
    .ex_control_out(c_ex), .mem_control_out(c_mem), .wb_control_out(c_wb),
    .stall_pc(c_spc), .stall_if_id(c_sif), .flush_if_id(c_fl),
    .stall_count(c_sc), .flush_count(c_fc), .fsm_state(c_st));

  function automatic logic model_hz();
    return id_valid && ex_mem_ctrl[0] && ex_wb_ctrl[0] &&
           ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
  endfunction

  // {ex, mem, wb, stall_pc, stall_if_id, flush_if_id}
  function automatic logic [14:0] model_ctrl(int i);
    if (reset) return '0;
    if (rem_flush[i] > 0 || branch_taken_ex) return 15'b001;
    if (rem_stall[i] > 0 || model_hz()) return 15'b110;
    if (id_valid) return {id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, 3'b000};
    return '0;
  endfunction

  function automatic logic [46:0] model_vec(int i);
    return {model_ctrl(i), 16'(m_sc[i]), 16'(m_fc[i])};
  endfunction

  function automatic logic [46:0] obs_vec(int i);
    case (i)
      0:       return {a_ex, a_mem, a_wb, a_spc, a_sif, a_fl, a_sc, a_fc};
      1:       return {b_ex, b_mem, b_wb, b_spc, b_sif, b_fl, b_sc, b_fc};
      default: return {c_ex, c_mem, c_wb, c_spc, c_sif, c_fl, 14'b0, c_sc, 14'b0, c_fc};
    endcase
  endfunction

  task automatic model_commit(int i);
    if (reset) begin
      rem_stall[i] = 0; rem_flush[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end else if (rem_flush[i] > 0) begin
      rem_flush[i]--;
    end else if (branch_taken_ex) begin
      if (m_fc[i] < cmax_p[i]) m_fc[i]++;
      rem_flush[i] = bfc_p[i] - 1;
      rem_stall[i] = 0;
    end else if (rem_stall[i] > 0) begin
      rem_stall[i]--;
    end else if (model_hz()) begin
      if (m_sc[i] < cmax_p[i]) m_sc[i]++;
      rem_stall[i] = lsc_p[i] - 1;
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) model_commit(i);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_uses_rn = 0; id_uses_rm = 0; branch_taken_ex = 0;
    id_ex_ctrl = 0; id_mem_ctrl = 0; id_wb_ctrl = 0; id_rn = 0; id_rm = 0;
    ex_rd = 0; ex_mem_ctrl = 0; ex_wb_ctrl = 0;
  endtask

  task automatic do_reset();
    reset = 1; set_idle();
    tick(); tick();
    reset = 0;
  endtask

  task automatic set_load_hazard();
    id_valid = 1; id_ex_ctrl = 4'h3; id_mem_ctrl = 4'h6; id_wb_ctrl = 4'h9;
    ex_mem_ctrl = 4'b0001; ex_wb_ctrl = 4'b0001; ex_rd = 5; id_rn = 5; id_uses_rn = 1;
  endtask

  task automatic test_reset();
    set_idle(); reset = 1; id_valid = 1; id_ex_ctrl = 4'hF; id_mem_ctrl = 4'hF;
    id_wb_ctrl = 4'hF; branch_taken_ex = 1; ex_mem_ctrl = 1; ex_wb_ctrl = 1; id_uses_rn = 1;
    #1;
    n_total++;
    if ({a_ex, a_mem, a_wb, a_spc, a_sif, a_fl, b_spc, b_fl, c_spc, c_fl} !== 19'b0)
      $display("FAIL reset_outputs: got a=%h%h%h %b%b%b want 0", a_ex, a_mem, a_wb, a_spc, a_sif, a_fl);
    else n_pass++;
    tick();
    n_total++;
    if ({a_st, a_sc, a_fc} !== 34'b0)
      $display("FAIL reset_state: got st=%0d sc=%0d fc=%0d want 0/0/0", a_st, a_sc, a_fc);
    else n_pass++;
    reset = 0; set_idle();
  endtask

  task automatic test_load_use();
    do_reset(); set_load_hazard(); #1;
    n_total++;
    if ({a_ex, a_mem, a_wb, a_spc, a_sif, a_fl} !== 15'b110)
      $display("FAIL load_use_stall: got %h%h%h %b%b%b want 000 110", a_ex, a_mem, a_wb, a_spc, a_sif, a_fl);
    else n_pass++;
    tick(); ex_mem_ctrl = 0; ex_wb_ctrl = 0; #1;
    n_total++;
    if ({a_ex, a_mem, a_wb, a_spc, a_sif, a_fl} !== {12'h369, 3'b000})
      $display("FAIL load_use_pass: got %h%h%h %b%b%b want 369 000", a_ex, a_mem, a_wb, a_spc, a_sif, a_fl);
    else n_pass++;
    n_total++;
    if (a_sc !== 16'd1) $display("FAIL load_use_count: got %0d want 1", a_sc);
    else n_pass++;
  endtask

  task automatic test_no_hazard();
    do_reset(); set_load_hazard(); id_rn = 3; id_rm = 5; id_uses_rm = 0; #1;
    n_total++;
    if ({a_ex, a_mem, a_wb, a_spc} !== {12'h369, 1'b0})
      $display("FAIL no_hz_unused_rm: got %h%h%h spc=%b want 369 0", a_ex, a_mem, a_wb, a_spc);
    else n_pass++;
    tick(); id_rn = 5; ex_mem_ctrl = 4'b0000; #1;
    n_total++;
    if (a_spc !== 1'b0) $display("FAIL no_hz_not_load: got spc=%b want 0", a_spc);
    else n_pass++;
    tick(); ex_mem_ctrl = 4'b0001; ex_wb_ctrl = 4'b0000; #1;
    n_total++;
    if (a_spc !== 1'b0) $display("FAIL no_hz_no_regwrite: got spc=%b want 0", a_spc);
    else n_pass++;
    tick(); ex_wb_ctrl = 4'b0001; id_valid = 0; #1;
    n_total++;
    if ({a_ex, a_mem, a_wb, a_spc} !== 13'b0)
      $display("FAIL no_hz_invalid_id: got %h%h%h spc=%b want 000 0", a_ex, a_mem, a_wb, a_spc);
    else n_pass++;
    tick();
    n_total++;
    if (a_sc !== 16'd0) $display("FAIL no_hz_count: got %0d want 0", a_sc);
    else n_pass++;
  endtask

  task automatic test_branch();
    do_reset(); id_valid = 1; id_ex_ctrl = 5; id_mem_ctrl = 5; id_wb_ctrl = 5;
    branch_taken_ex = 1; #1;
    n_total++;
    if ({a_ex, a_mem, a_wb, a_spc, a_fl} !== 14'b01)
      $display("FAIL branch_cyc1: got %h%h%h spc=%b fl=%b want 000 0 1", a_ex, a_mem, a_wb, a_spc, a_fl);
    else n_pass++;
    tick(); #1;
    n_total++;
    if ({a_ex, a_mem, a_wb, a_fl, a_fc} !== {13'b1, 16'd1})
      $display("FAIL branch_cyc2: got %h%h%h fl=%b fc=%0d want 000 1 1", a_ex, a_mem, a_wb, a_fl, a_fc);
    else n_pass++;
    tick(); branch_taken_ex = 0; #1;
    n_total++;
    if ({a_ex, a_mem, a_wb, a_fl, a_fc} !== {12'h555, 1'b0, 16'd1})
      $display("FAIL branch_done: got %h%h%h fl=%b fc=%0d want 555 0 1", a_ex, a_mem, a_wb, a_fl, a_fc);
    else n_pass++;
  endtask

  task automatic test_branch_hz();
    do_reset(); set_load_hazard(); branch_taken_ex = 1; #1;
    n_total++;
    if ({a_spc, a_sif, a_fl} !== 3'b001)
      $display("FAIL branch_hz_out: got spc=%b sif=%b fl=%b want 0 0 1", a_spc, a_sif, a_fl);
    else n_pass++;
    tick(); branch_taken_ex = 0; ex_mem_ctrl = 0;
    n_total++;
    if ({a_sc, a_fc} !== {16'd0, 16'd1})
      $display("FAIL branch_hz_cnt: got sc=%0d fc=%0d want 0 1", a_sc, a_fc);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset(); set_load_hazard();
    repeat (5) tick();
    n_total++;
    if ({c_sc, a_sc} !== {2'd3, 16'd5})
      $display("FAIL saturation: got c=%0d a=%0d want 3 5", c_sc, a_sc);
    else n_pass++;
  endtask

  task automatic test_lu_abort();
    do_reset(); set_load_hazard(); tick();
    ex_mem_ctrl = 0; #1;
    n_total++;
    if (b_spc !== 1'b1) $display("FAIL lu_hold: got spc=%b want 1", b_spc);
    else n_pass++;
    branch_taken_ex = 1; #1;
    n_total++;
    if ({b_spc, b_fl} !== 2'b01) $display("FAIL lu_abort: got spc=%b fl=%b want 0 1", b_spc, b_fl);
    else n_pass++;
    tick(); branch_taken_ex = 0; tick(); #1;
    n_total++;
    if ({b_fl, b_fc, b_sc} !== {1'b1, 16'd1, 16'd1})
      $display("FAIL lu_abort_flush3: got fl=%b fc=%0d sc=%0d want 1 1 1", b_fl, b_fc, b_sc);
    else n_pass++;
    tick(); #1;
    n_total++;
    if ({b_fl, b_st} !== 3'b0) $display("FAIL lu_abort_end: got fl=%b st=%0d want 0 0", b_fl, b_st);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset(); set_load_hazard(); tick();
    reset = 1; #1;
    n_total++;
    if ({b_ex, b_mem, b_wb, b_spc, b_sif, b_fl} !== 15'b0)
      $display("FAIL rst_mid_out: got %h%h%h %b%b%b want 0", b_ex, b_mem, b_wb, b_spc, b_sif, b_fl);
    else n_pass++;
    tick();
    n_total++;
    if ({b_st, b_sc, b_fc, b_spc} !== 35'b0)
      $display("FAIL rst_mid_state: got st=%0d sc=%0d fc=%0d spc=%b want 0", b_st, b_sc, b_fc, b_spc);
    else n_pass++;
    reset = 0; set_idle(); id_valid = 1; id_ex_ctrl = 4'hA; #1;
    n_total++;
    if ({b_ex, b_spc} !== {4'hA, 1'b0}) $display("FAIL rst_mid_pass: got ex=%h spc=%b want a 0", b_ex, b_spc);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [46:0] exp_v, obs_v;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = ($urandom_range(0, 39) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_ex_ctrl = 4'($urandom); id_mem_ctrl = 4'($urandom); id_wb_ctrl = 4'($urandom);
      id_rn = 4'($urandom_range(0, 3)); id_rm = 4'($urandom_range(0, 3));
      ex_rd = 4'($urandom_range(0, 3));
      id_uses_rn = 1'($urandom); id_uses_rm = 1'($urandom);
      ex_mem_ctrl = 4'($urandom); ex_wb_ctrl = 4'($urandom);
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(model_vec(i));
        obs_v = obs_vec(i);
        exp_v = exp_q.pop_front();
        n_total++;
        if (obs_v !== exp_v)
          $display("FAIL random inst%0d cyc%0d: got %h want %h", i, cyc, obs_v, exp_v);
        else n_pass++;
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    set_idle();
    for (int i = 0; i < 3; i++) begin
      rem_stall[i] = 0; rem_flush[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_branch_hz();
    test_saturation();
    test_lu_abort();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
